// File: rtl/ipml_fifo_rr_arbiter_if.sv
// Handshake bundle between the prefetch FIFOs, the round-robin read
// scheduler and the downstream consumer. The scheduler takes the master
// modport. The FIFO/consumer environment takes the slave modport.
interface ipml_fifo_rr_arbiter_if #(
  parameter int c_N_PORTS = 4,
  parameter int c_W       = 32
);
  localparam int PW = (c_N_PORTS > 1) ? $clog2(c_N_PORTS) : 1;

  logic [c_N_PORTS-1:0]     src_vld;
  logic [c_N_PORTS*c_W-1:0] src_data;
  logic [c_N_PORTS-1:0]     src_en;
  logic [c_N_PORTS-1:0]     port_mask;
  logic [c_W-1:0]           dst_data;
  logic                     dst_vld;
  logic                     dst_rdy;
  logic [PW-1:0]            dst_port;
  logic                     dst_last;

  modport master (
    input  src_vld, src_data, port_mask, dst_rdy,
    output src_en, dst_data, dst_vld, dst_port, dst_last
  );

  modport slave (
    output src_vld, src_data, port_mask, dst_rdy,
    input  src_en, dst_data, dst_vld, dst_port, dst_last
  );
endinterface

// File: rtl/ipml_fifo_rr_arbiter.sv
// Round-robin read scheduler: shares one valid/ready consumer between
// c_N_PORTS prefetch FIFOs, with grants limited to c_BURST beats.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no grant; pick the next requester starting at ptr (bubble cycle)
// S_GRANT | port gnt drives dst; exits on burst limit or when its FIFO runs dry
module ipml_fifo_rr_arbiter #(
  parameter int c_N_PORTS = 4,
  parameter int c_W       = 32,
  parameter int c_BURST   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ipml_fifo_rr_arbiter_if.master bus
);
  localparam int PW = (c_N_PORTS > 1) ? $clog2(c_N_PORTS) : 1;
  localparam int CW = (c_BURST > 1) ? $clog2(c_BURST) : 1;

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_GRANT  = 1'b1;
  localparam logic [PW:0]   NP       = (PW+1)'(c_N_PORTS);
  localparam logic [PW-1:0] LAST_IDX = PW'(c_N_PORTS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(c_BURST - 1);

  logic [0:0]           state;
  logic [PW-1:0]        gnt;
  logic [PW-1:0]        ptr;
  logic [CW-1:0]        cnt;
  logic [c_N_PORTS-1:0] req;
  logic [PW-1:0]        pick;
  logic                 found;
  logic [PW:0]          idx;
  logic [PW-1:0]        gnt_inc;
  logic                 vld_g;
  logic                 beat;
  logic                 at_limit;

  assign req      = bus.src_vld & bus.port_mask;
  assign vld_g    = bus.src_vld[gnt];
  assign beat     = (state == S_GRANT) & vld_g & bus.dst_rdy;
  assign at_limit = (cnt == CNT_LAST);
  assign gnt_inc  = (gnt == LAST_IDX) ? '0 : gnt + 1'b1;

  // Rotating priority search: first requester at ptr, ptr+1, ... with wrap.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < c_N_PORTS; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= NP) idx = idx - NP;
      if (!found && req[idx[PW-1:0]]) begin
        pick  = idx[PW-1:0];
        found = 1'b1;
      end
    end
  end

  // Consumer-side outputs and FIFO pops, gated by the current grant.
  always_comb begin
    bus.src_en   = '0;
    bus.dst_vld  = 1'b0;
    bus.dst_last = 1'b0;
    if (state == S_GRANT) begin
      bus.dst_vld      = vld_g;
      bus.dst_last     = vld_g & at_limit;
      bus.src_en[gnt]  = bus.dst_rdy & vld_g;
    end
  end

  // The data mux follows gnt even in IDLE, so port 0 data shows after reset.
  assign bus.dst_data = bus.src_data[int'(gnt)*c_W +: c_W];
  assign bus.dst_port = gnt;

  // Grant FSM: arbitrate in IDLE, count beats in GRANT, rotate ptr on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt   <= pick;
            cnt   <= '0;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!vld_g || (beat && at_limit)) begin
            state <= S_IDLE;
            ptr   <= gnt_inc;
          end else if (beat) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
